power_domain_sequencer: RTL and testbench
=========================================

# power_domain_sequencer

Sequences power-switch, isolation, retention and clock-enable controls for the accelerator's power domains. It takes per-domain on/off requests from the power management unit, arbitrates them round-robin, and runs at most one domain transition at a time to bound inrush current. It reports settled domain status and sticky switch-acknowledge timeouts.

## Interface
- NUM_DOMAINS, 16, number of power domains (2..32)
- SETTLE_CYCLES, 4, rail settle wait after switch ack (1..255)
- ACK_TIMEOUT, 255, max cycles waiting for sw_ack (1..65535)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_on  in  NUM_DOMAINS  desired state per domain (1 = on), level
- sw_ack  in  NUM_DOMAINS  power-switch chain acknowledge, synchronous to clk
- err_clr  in  NUM_DOMAINS  1-cycle pulse; clears err_timeout bit and unmasks domain
- pwr_sw_en  out  NUM_DOMAINS  power switch enable
- iso_en  out  NUM_DOMAINS  isolation clamp enable (1 = isolated)
- clk_en  out  NUM_DOMAINS  domain clock enable
- ret_save  out  NUM_DOMAINS  1-cycle retention save pulse
- ret_restore  out  NUM_DOMAINS  1-cycle retention restore pulse
- dom_on  out  NUM_DOMAINS  domain fully on and de-isolated
- busy  out  1  transition in progress
- err_timeout  out  NUM_DOMAINS  sticky ack-timeout flag

## Operation
- Pending[i] = (req_on[i] != dom_on[i]) & ~err_timeout[i].
- FSM: IDLE, UP_SW, UP_SETTLE, UP_RESTORE, UP_CLK, DN_ISO, DN_CLK, DN_SAVE, DN_SW.
- IDLE: if any pending, grant lowest index >= rr_ptr (wrapping); rr_ptr <= grant+1 (mod NUM_DOMAINS); latch index; go UP_SW if req_on=1, else DN_ISO. busy = state != IDLE.
- Up: UP_SW sets pwr_sw_en=1 and waits for sw_ack=1 -> UP_SETTLE waits SETTLE_CYCLES -> UP_RESTORE pulses ret_restore -> UP_CLK sets clk_en=1 -> IDLE, clearing iso_en and setting dom_on.
- Down: DN_ISO sets iso_en=1 and clears dom_on -> DN_CLK clears clk_en -> DN_SAVE pulses ret_save -> DN_SW clears pwr_sw_en and waits for sw_ack=0 -> IDLE.
- Timeout: an 16-bit counter runs in UP_SW/DN_SW. On reaching ACK_TIMEOUT without the expected ack: set err_timeout[i], clear pwr_sw_en[i] and go IDLE. Up abort leaves the domain isolated with dom_on=0 and clk_en=0. Down abort leaves dom_on=0.
- A req_on change for the granted domain mid-sequence is ignored until the sequence completes, then re-arbitrated.
- err_clr and a timeout on the same bit in the same cycle: set wins.
- A domain with err_timeout set is masked from arbitration.
- Only the granted domain's outputs change. All others hold.

## Timing
- Reset values: pwr_sw_en=0, iso_en=all 1, clk_en=0, ret_save=0, ret_restore=0, dom_on=0, busy=0, err_timeout=0, rr_ptr=0, state IDLE.
- All outputs are registered. Grant occurs on the edge where IDLE sees pending. pwr_sw_en or iso_en changes on that same edge.
- Up latency with sw_ack already high: pwr_sw_en rises at edge E. UP_SETTLE is entered at E+1. ret_restore is high for one cycle after SETTLE_CYCLES. clk_en rises one cycle later. iso_en falls and dom_on rises one cycle after that. dom_on rises at E+SETTLE_CYCLES+3.
- Down latency with sw_ack already low: iso_en=1 and dom_on=0 at E. clk_en=0 at E+1. ret_save pulse at E+2. pwr_sw_en=0 at E+3. IDLE at E+4.
- Back-to-back transitions need one IDLE cycle between sequences.
- Reset mid-sequence returns all outputs to reset values immediately (asynchronously).

## Configuration
- PDS_RETENTION_EN: when defined, UP_RESTORE and DN_SAVE run as above.
- When undefined, both states are skipped. ret_save and ret_restore are tied to 0. Up latency becomes SETTLE_CYCLES+2 and down latency becomes 3.

## Structure
- Package pds_pkg: the state enum pds_state_t, the timeout counter width constant, and the default SETTLE_CYCLES and ACK_TIMEOUT values.
- Sub-module pds_rr_arbiter: combinational round-robin priority pick from the pending vector and rr_ptr, outputting grant_valid and grant_idx.

## Test plan
- req_on[3] rises, sw_ack follows pwr_sw_en after 2 cycles, SETTLE_CYCLES=4 -> dom_on[3]=1, iso_en[3]=0, and exactly one ret_restore[3] pulse.
- req_on[0] and req_on[5] rise together with rr_ptr=0 -> domain 0 is sequenced fully, then domain 5. busy stays high except for one IDLE cycle between them.
- Domain 7 on, then req_on[7] falls -> order is iso_en=1, then clk_en=0, then ret_save pulse, then pwr_sw_en=0. dom_on[7]=0 from the first step.
- sw_ack[2] held at 0 with ACK_TIMEOUT=10 -> err_timeout[2]=1 after 10 cycles in UP_SW, pwr_sw_en[2]=0, domain masked. err_clr[2] pulse -> sequence retried.
- rst_n asserted during UP_SETTLE -> all outputs at reset values on the next sample, with iso_en=all 1.
- Build without PDS_RETENTION_EN -> ret_* remain 0 throughout, and the up sequence is SETTLE_CYCLES+2 edges.

Source files
------------

// File: rtl/pds_pkg.sv
// Shared types and constants for the power domain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pds_pkg;

  // One transition at a time; UP_RESTORE and DN_SAVE are only visited when
  // retention support is built in.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    UP_SW      = 4'd1,
    UP_SETTLE  = 4'd2,
    UP_RESTORE = 4'd3,
    UP_CLK     = 4'd4,
    DN_ISO     = 4'd5,
    DN_CLK     = 4'd6,
    DN_SAVE    = 4'd7,
    DN_SW      = 4'd8
  } pds_state_t;

  // Shared settle / ack-timeout counter width.
  localparam int TO_CNT_W = 16;

  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int DEFAULT_ACK_TIMEOUT   = 255;

endpackage

// File: rtl/pds_rr_arbiter.sv
// Round-robin pick of the lowest pending domain index at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the sequencer only samples the grant while idle.
module pds_rr_arbiter #(
  parameter int NUM_DOMAINS = 16,
  parameter int IDX_W       = $clog2(NUM_DOMAINS)
) (
  input  logic [NUM_DOMAINS-1:0] pending,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  int j;

  // Scan from rr_ptr upward, wrapping once; first pending domain wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_DOMAINS) j = j - NUM_DOMAINS;
      if (!grant_valid && pending[j[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/power_domain_sequencer.sv
// Sequences switch/isolation/retention/clock controls, one domain transition at a time.
// Latency: up = SETTLE_CYCLES+3 edges (+2 without PDS_RETENTION_EN), down = 4 (3), plus ack wait.
// Backpressure: none; req_on is a level, re-arbitrated after each sequence. Option: PDS_RETENTION_EN.
module power_domain_sequencer
  import pds_pkg::*;
#(
  parameter int NUM_DOMAINS   = 16,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int ACK_TIMEOUT   = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DOMAINS-1:0] req_on,
  input  logic [NUM_DOMAINS-1:0] sw_ack,
  input  logic [NUM_DOMAINS-1:0] err_clr,
  output logic [NUM_DOMAINS-1:0] pwr_sw_en,
  output logic [NUM_DOMAINS-1:0] iso_en,
  output logic [NUM_DOMAINS-1:0] clk_en,
  output logic [NUM_DOMAINS-1:0] ret_save,
  output logic [NUM_DOMAINS-1:0] ret_restore,
  output logic [NUM_DOMAINS-1:0] dom_on,
  output logic                   busy,
  output logic [NUM_DOMAINS-1:0] err_timeout
);

  localparam int IDX_W = $clog2(NUM_DOMAINS);
  localparam logic [TO_CNT_W-1:0] SETTLE_LAST = TO_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_CNT_W-1:0] ACK_LAST    = TO_CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]    IDX_MAX     = IDX_W'(NUM_DOMAINS - 1);

  pds_state_t             state;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       rr_ptr;
  logic [TO_CNT_W-1:0]    cnt;
  logic [NUM_DOMAINS-1:0] pending;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;

  // A domain wants service when its request disagrees with its settled state,
  // unless a previous switch timeout has parked it.
  assign pending = (req_on ^ dom_on) & ~err_timeout;

  pds_rr_arbiter #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifndef PDS_RETENTION_EN
  assign ret_save    = '0;
  assign ret_restore = '0;
`endif

  // Sequencer FSM; every output is a register updated only for the granted domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_idx     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      pwr_sw_en   <= '0;
      iso_en      <= '1;
      clk_en      <= '0;
      dom_on      <= '0;
      err_timeout <= '0;
`ifdef PDS_RETENTION_EN
      ret_save    <= '0;
      ret_restore <= '0;
`endif
    end else begin
`ifdef PDS_RETENTION_EN
      ret_save    <= '0;
      ret_restore <= '0;
`endif
      // A timeout set below overrides a same-cycle clear for that bit.
      err_timeout <= err_timeout & ~err_clr;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_idx <= grant_idx;
            rr_ptr  <= (grant_idx == IDX_MAX) ? '0 : grant_idx + IDX_W'(1);
            cnt     <= '0;
            busy    <= 1'b1;
            if (req_on[grant_idx]) begin
              pwr_sw_en[grant_idx] <= 1'b1;
              state                <= UP_SW;
            end else begin
              iso_en[grant_idx] <= 1'b1;
              dom_on[grant_idx] <= 1'b0;
              state             <= DN_ISO;
            end
          end
        end

        UP_SW: begin
          if (sw_ack[cur_idx]) begin
            cnt   <= '0;
            state <= UP_SETTLE;
          end else if (cnt == ACK_LAST) begin
            // Abort: domain stays isolated, clock off, and is masked until cleared.
            err_timeout[cur_idx] <= 1'b1;
            pwr_sw_en[cur_idx]   <= 1'b0;
            busy                 <= 1'b0;
            state                <= IDLE;
          end else begin
            cnt <= cnt + TO_CNT_W'(1);
          end
        end

        UP_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
`ifdef PDS_RETENTION_EN
            ret_restore[cur_idx] <= 1'b1;
            state                <= UP_RESTORE;
`else
            clk_en[cur_idx] <= 1'b1;
            state           <= UP_CLK;
`endif
          end else begin
            cnt <= cnt + TO_CNT_W'(1);
          end
        end

`ifdef PDS_RETENTION_EN
        UP_RESTORE: begin
          clk_en[cur_idx] <= 1'b1;
          state           <= UP_CLK;
        end
`endif

        UP_CLK: begin
          iso_en[cur_idx] <= 1'b0;
          dom_on[cur_idx] <= 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end

        DN_ISO: begin
          clk_en[cur_idx] <= 1'b0;
          state           <= DN_CLK;
        end

        DN_CLK: begin
`ifdef PDS_RETENTION_EN
          ret_save[cur_idx] <= 1'b1;
          state             <= DN_SAVE;
`else
          pwr_sw_en[cur_idx] <= 1'b0;
          cnt                <= '0;
          state              <= DN_SW;
`endif
        end

`ifdef PDS_RETENTION_EN
        DN_SAVE: begin
          pwr_sw_en[cur_idx] <= 1'b0;
          cnt                <= '0;
          state              <= DN_SW;
        end
`endif

        DN_SW: begin
          if (!sw_ack[cur_idx]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == ACK_LAST) begin
            err_timeout[cur_idx] <= 1'b1;
            pwr_sw_en[cur_idx]   <= 1'b0;
            busy                 <= 1'b0;
            state                <= IDLE;
          end else begin
            cnt <= cnt + TO_CNT_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Self-checking bench: expected control-edge events are queued as stimulus is applied
// and matched in order against edges observed on the DUT outputs.
// sw_ack follows pwr_sw_en through two flops unless a domain is forced stuck low.
`timescale 1ns/1ps
module tb_power_domain_sequencer;

  localparam int N  = 16;
  localparam int S  = 4;
  localparam int TO = 10;
`ifdef PDS_RETENTION_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int K_PWR = 0, K_ISO = 1, K_CLK = 2, K_RSAVE = 3, K_RREST = 4, K_DOM = 5, K_ERR = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_on, err_clr, ack_stuck, sw_ack;
  logic [N-1:0] ack_d1, ack_d2;
  logic [N-1:0] pwr_sw_en, iso_en, clk_en, ret_save, ret_restore, dom_on, err_timeout;
  logic         busy;

  int checks;
  int errors;
  int cyc;
  logic sb_en;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  power_domain_sequencer #(
    .NUM_DOMAINS   (N),
    .SETTLE_CYCLES (S),
    .ACK_TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_on      (req_on),
    .sw_ack      (sw_ack),
    .err_clr     (err_clr),
    .pwr_sw_en   (pwr_sw_en),
    .iso_en      (iso_en),
    .clk_en      (clk_en),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .dom_on      (dom_on),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_d1 <= '0;
      ack_d2 <= '0;
    end else begin
      ack_d1 <= pwr_sw_en;
      ack_d2 <= ack_d1;
    end
  end
  assign sw_ack = ack_d2 & ~ack_stuck;

  function automatic logic [31:0] ev(int c, int k, int d, int v);
    return {c[15:0], k[3:0], d[7:0], v[3:0]};
  endfunction

  // Records every output edge as {cycle, kind, domain, new value}.
  task automatic monitor();
    logic [N-1:0] prev [7];
    logic [N-1:0] cur  [7];
    for (int k = 0; k < 7; k++) prev[k] = '0;
    forever begin
      @(negedge clk);
      cur[0] = pwr_sw_en; cur[1] = iso_en; cur[2] = clk_en; cur[3] = ret_save;
      cur[4] = ret_restore; cur[5] = dom_on; cur[6] = err_timeout;
      if (sb_en)
        for (int k = 0; k < 7; k++)
          for (int d = 0; d < N; d++)
            if (cur[k][d] !== prev[k][d]) obs_q.push_back(ev(cyc, k, d, int'(cur[k][d])));
      for (int k = 0; k < 7; k++) prev[k] = cur[k];
    end
  endtask

  // Power-up of domain d granted at edge e, sw_ack arriving two cycles after pwr_sw_en.
  task automatic push_up(int e, int d);
    exp_q.push_back(ev(e, K_PWR, d, 1));
    if (R == 1) exp_q.push_back(ev(e + S + 3, K_RREST, d, 1));
    exp_q.push_back(ev(e + S + 3 + R, K_CLK, d, 1));
    if (R == 1) exp_q.push_back(ev(e + S + 4, K_RREST, d, 0));
    exp_q.push_back(ev(e + S + 4 + R, K_ISO, d, 0));
    exp_q.push_back(ev(e + S + 4 + R, K_DOM, d, 1));
  endtask

  task automatic push_down(int e, int d);
    exp_q.push_back(ev(e, K_ISO, d, 1));
    exp_q.push_back(ev(e, K_DOM, d, 0));
    exp_q.push_back(ev(e + 1, K_CLK, d, 0));
    if (R == 1) exp_q.push_back(ev(e + 2, K_RSAVE, d, 1));
    exp_q.push_back(ev(e + 2 + R, K_PWR, d, 0));
    if (R == 1) exp_q.push_back(ev(e + 3, K_RSAVE, d, 0));
  endtask

  task automatic do_reset();
    sb_en     = 1'b0;
    req_on    = '0;
    err_clr   = '0;
    ack_stuck = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_on = '0; err_clr = '0; ack_stuck = '0; sb_en = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (pwr_sw_en !== '0) begin errors++; $display("FAIL rst_pwr: got %h want 0", pwr_sw_en); end
    checks++; if (iso_en !== '1) begin errors++; $display("FAIL rst_iso: got %h want ffff", iso_en); end
    checks++; if (clk_en !== '0 || dom_on !== '0) begin errors++; $display("FAIL rst_clk_dom: clk_en %h dom_on %h want 0", clk_en, dom_on); end
    checks++; if (ret_save !== '0 || ret_restore !== '0) begin errors++; $display("FAIL rst_ret: %h %h want 0", ret_save, ret_restore); end
    checks++; if (busy !== 1'b0 || err_timeout !== '0) begin errors++; $display("FAIL rst_busy_err: busy %b err %h want 0", busy, err_timeout); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy %b want 0 with no requests", busy); end
    sb_en = 1'b1;
  endtask

  task automatic test_power_up();
    logic [31:0] e, o;
    int c0;
    @(negedge clk);
    c0 = cyc;
    req_on[3] = 1'b1;
    push_up(c0 + 1, 3);
    repeat (S + 12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL up_events: missing event, expected %h (cyc/kind/dom/val)", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL up_events: observed %h expected %h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL up_events: %0d unexpected events, first %h", obs_q.size(), obs_q[0]); obs_q.delete(); end
    checks++; if (dom_on[3] !== 1'b1 || iso_en[3] !== 1'b0 || clk_en[3] !== 1'b1) begin
      errors++; $display("FAIL up_final: dom %b iso %b clk %b want 1 0 1", dom_on[3], iso_en[3], clk_en[3]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    int c0, e1, e2, idle;
    do_reset();
    @(negedge clk);
    c0 = cyc;
    req_on[0] = 1'b1;
    req_on[5] = 1'b1;
    e1 = c0 + 1;
    e2 = e1 + S + 5 + R;
    push_up(e1, 0);
    push_up(e2, 5);
    idle = 0;
    for (int i = 0; i < e2 + S + 4 + R - e1; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) idle++;
    end
    checks++; if (idle != 1) begin errors++; $display("FAIL b2b_busy: idle cycles %0d want 1", idle); end
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_events: missing event, expected %h (cyc/kind/dom/val)", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_events: observed %h expected %h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_events: %0d unexpected events, first %h", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_power_down();
    logic [31:0] e, o;
    int c0;
    @(negedge clk);
    c0 = cyc;
    req_on[7] = 1'b1;
    push_up(c0 + 1, 7);
    repeat (S + 10) @(negedge clk);
    c0 = cyc;
    req_on[7] = 1'b0;
    push_down(c0 + 1, 7);
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL down_events: missing event, expected %h (cyc/kind/dom/val)", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL down_events: observed %h expected %h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL down_events: %0d unexpected events, first %h", obs_q.size(), obs_q[0]); obs_q.delete(); end
    checks++; if (dom_on[7] !== 1'b0 || iso_en[7] !== 1'b1 || pwr_sw_en[7] !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL down_final: dom %b iso %b pwr %b busy %b want 0 1 0 0", dom_on[7], iso_en[7], pwr_sw_en[7], busy); end
  endtask

  task automatic test_timeout();
    logic [31:0] e, o;
    int c0;
    ack_stuck[2] = 1'b1;
    @(negedge clk);
    c0 = cyc;
    req_on[2] = 1'b1;
    exp_q.push_back(ev(c0 + 1, K_PWR, 2, 1));
    exp_q.push_back(ev(c0 + 1 + TO, K_PWR, 2, 0));
    exp_q.push_back(ev(c0 + 1 + TO, K_ERR, 2, 1));
    // Clear pulse lands on the same edge as the timeout; the set must win.
    repeat (TO) @(negedge clk);
    err_clr[2] = 1'b1;
    @(negedge clk);
    err_clr[2] = 1'b0;
    checks++; if (err_timeout[2] !== 1'b1 || pwr_sw_en[2] !== 1'b0) begin
      errors++; $display("FAIL to_flag: err %b pwr %b want 1 0", err_timeout[2], pwr_sw_en[2]); end
    checks++; if (iso_en[2] !== 1'b1 || clk_en[2] !== 1'b0 || dom_on[2] !== 1'b0) begin
      errors++; $display("FAIL to_state: iso %b clk %b dom %b want 1 0 0", iso_en[2], clk_en[2], dom_on[2]); end
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_masked: busy %b want 0 while masked", busy); end
    ack_stuck[2] = 1'b0;
    c0 = cyc;
    err_clr[2] = 1'b1;
    @(negedge clk);
    err_clr[2] = 1'b0;
    exp_q.push_back(ev(c0 + 1, K_ERR, 2, 0));
    push_up(c0 + 2, 2);
    repeat (S + 10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL to_events: missing event, expected %h (cyc/kind/dom/val)", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL to_events: observed %h expected %h", o, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL to_events: %0d unexpected events, first %h", obs_q.size(), obs_q[0]); obs_q.delete(); end
    checks++; if (dom_on[2] !== 1'b1 || err_timeout[2] !== 1'b0) begin
      errors++; $display("FAIL to_retry: dom %b err %b want 1 0", dom_on[2], err_timeout[2]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_on[1] = 1'b1;
    // Grant at the next edge; UP_SETTLE occupies edges +3 .. +S+2.
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1 || pwr_sw_en[1] !== 1'b1) begin
      errors++; $display("FAIL mid_pre: busy %b pwr %b want 1 1", busy, pwr_sw_en[1]); end
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (pwr_sw_en !== '0 || clk_en !== '0 || dom_on !== '0) begin
      errors++; $display("FAIL mid_rst: pwr %h clk %h dom %h want 0", pwr_sw_en, clk_en, dom_on); end
    checks++; if (iso_en !== '1) begin errors++; $display("FAIL mid_rst_iso: got %h want ffff", iso_en); end
    checks++; if (busy !== 1'b0 || err_timeout !== '0 || ret_save !== '0 || ret_restore !== '0) begin
      errors++; $display("FAIL mid_rst_misc: busy %b err %h rs %h rr %h want 0", busy, err_timeout, ret_save, ret_restore); end
    req_on = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || pwr_sw_en !== '0) begin
      errors++; $display("FAIL mid_after: busy %b pwr %h want 0", busy, pwr_sw_en); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_power_up();
    test_back_to_back();
    test_power_down();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
